// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control bus between the sequencer and the multicycle datapath
// Ports (signals):
//   Opcode, Zero       datapath -> control: IR[31:26] and the ALU zero flag
//   PCWrite..Halted    control -> datapath: selector controls, ALU op, write enables
//   InstrCount         control -> datapath: retired-instruction counter
// Modports: master = control unit, slave = datapath.
interface multicycle_control_unit_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [5:0]             Opcode;
    logic                   Zero;
    logic                   PCWrite;
    logic [1:0]             PCSrc;
    logic                   IRWrite;
    logic                   ALUSrcA;
    logic                   ALUSrcB;
    logic                   ExtSel;
    logic [2:0]             ALUOp;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   RegDst;
    logic                   MemToReg;
    logic                   RegWrite;
    logic                   Halted;
    logic [COUNT_WIDTH-1:0] InstrCount;

    modport master (
        input  Opcode, Zero,
        output PCWrite, PCSrc, IRWrite, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               MemRead, MemWrite, RegDst, MemToReg, RegWrite, Halted, InstrCount
    );

    modport slave (
        output Opcode, Zero,
        input  PCWrite, PCSrc, IRWrite, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               MemRead, MemWrite, RegDst, MemToReg, RegWrite, Halted, InstrCount
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EXE/MEM/WB sequencer for the multicycle CPU datapath
// Ports:
//   CLK    clock, all state changes on the rising edge
//   Reset  synchronous active-high; forces state IF, clears InstrCount, gates all outputs to 0
//   bus    master side of multicycle_control_unit_if (Opcode/Zero in, controls and InstrCount out)
module multicycle_control_unit #(
    parameter int COUNT_WIDTH = 32
) (
    input logic                        CLK,
    input logic                        Reset,
    multicycle_control_unit_if.master  bus
);
    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EXE_AL = 4'd2;
    localparam logic [3:0] S_EXE_BR = 4'd3;
    localparam logic [3:0] S_EXE_LS = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB_AL  = 4'd6;
    localparam logic [3:0] S_WB_LD  = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [3:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;
    logic is_sw, is_lw, is_beq, is_j, is_halt, is_r, is_alu, is_nop, exe_wb;

    logic       pc_write, ir_write, alu_src_a, alu_src_b, ext_sel;
    logic       mem_read, mem_write, reg_dst, mem_to_reg, reg_write, halted;
    logic [1:0] pc_src;
    logic [2:0] alu_op;

    assign is_add  = bus.Opcode == OP_ADD;
    assign is_sub  = bus.Opcode == OP_SUB;
    assign is_addi = bus.Opcode == OP_ADDI;
    assign is_or   = bus.Opcode == OP_OR;
    assign is_and  = bus.Opcode == OP_AND;
    assign is_ori  = bus.Opcode == OP_ORI;
    assign is_sll  = bus.Opcode == OP_SLL;
    assign is_slt  = bus.Opcode == OP_SLT;
    assign is_sw   = bus.Opcode == OP_SW;
    assign is_lw   = bus.Opcode == OP_LW;
    assign is_beq  = bus.Opcode == OP_BEQ;
    assign is_j    = bus.Opcode == OP_J;
    assign is_halt = bus.Opcode == OP_HALT;
    assign is_r    = is_add | is_sub | is_and | is_or | is_slt;
    assign is_alu  = is_r | is_sll | is_addi | is_ori;
    // Anything not decoded retires as a two-cycle nop.
    assign is_nop  = !(is_alu | is_beq | is_lw | is_sw | is_j | is_halt);
    // Opcode-static controls are driven in every state from EXE through WB.
    assign exe_wb  = state_q >= S_EXE_AL && state_q <= S_WB_LD;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IF;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:     state_d = S_ID;
            S_ID:     state_d = is_halt ? S_HALT : is_alu ? S_EXE_AL : is_beq ? S_EXE_BR :
                                (is_lw | is_sw) ? S_EXE_LS : S_IF;
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        reg_dst    = exe_wb & (is_r | is_sll);
        alu_src_a  = exe_wb & is_sll;
        alu_src_b  = exe_wb & (is_addi | is_ori | is_lw | is_sw);
        ext_sel    = exe_wb & (is_addi | is_lw | is_sw | is_beq);
        alu_op     = !exe_wb ? 3'b000 : (is_sub | is_beq) ? 3'b001 : is_and ? 3'b010 :
                     (is_or | is_ori) ? 3'b011 : is_sll ? 3'b100 : is_slt ? 3'b101 : 3'b000;
        case (state_q)
            S_IF:     ir_write = 1'b1;
            S_ID: begin
                pc_write = is_j | is_nop;
                pc_src   = is_j ? 2'b10 : 2'b00;
            end
            S_EXE_BR: begin
                pc_write = 1'b1;
                pc_src   = bus.Zero ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                mem_write = is_sw;
                pc_write  = is_sw;
                mem_read  = is_lw;
            end
            S_WB_AL: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            S_WB_LD: begin
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
        // Illegal encodings drive nothing, not even the EXE/WB statics.
        if (state_q > S_HALT) begin
            reg_dst   = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            ext_sel   = 1'b0;
            alu_op    = 3'b000;
        end
    end

    // Reset gates every output so no write can slip out in the reset cycle.
    assign bus.PCWrite  = !Reset & pc_write;
    assign bus.PCSrc    = Reset ? 2'b00 : pc_src;
    assign bus.IRWrite  = !Reset & ir_write;
    assign bus.ALUSrcA  = !Reset & alu_src_a;
    assign bus.ALUSrcB  = !Reset & alu_src_b;
    assign bus.ExtSel   = !Reset & ext_sel;
    assign bus.ALUOp    = Reset ? 3'b000 : alu_op;
    assign bus.MemRead  = !Reset & mem_read;
    assign bus.MemWrite = !Reset & mem_write;
    assign bus.RegDst   = !Reset & reg_dst;
    assign bus.MemToReg = !Reset & mem_to_reg;
    assign bus.RegWrite = !Reset & reg_write;
    assign bus.Halted   = !Reset & halted;

    assign count_d        = count_q + COUNT_WIDTH'(bus.PCWrite);
    assign bus.InstrCount = count_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed bench with a phase-based reference model and per-cycle compare
module tb_multicycle_control_unit;
    localparam logic [5:0] ADD  = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR_ = 6'b010000;
    localparam logic [5:0] AND_ = 6'b010001, ORI = 6'b010010, SLL  = 6'b011000, SLT = 6'b100110;
    localparam logic [5:0] SW   = 6'b110000, LW  = 6'b110001, BEQ  = 6'b110100, J   = 6'b111000;
    localparam logic [5:0] HALT = 6'b111111, NOP = 6'b101010;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int   passed = 0, total = 0;
    bit   chk_en = 1'b0, resync = 1'b0;
    int   ph = 0;
    bit   hlt = 1'b0;
    logic [31:0] mcnt = '0;
    logic [15:0] dut_v;

    multicycle_control_unit_if #(.COUNT_WIDTH(32)) bus ();
    multicycle_control_unit #(.COUNT_WIDTH(32)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always #5 CLK = ~CLK;

    assign dut_v = {bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel,
                    bus.ALUOp, bus.MemRead, bus.MemWrite, bus.RegDst, bus.MemToReg, bus.RegWrite,
                    bus.Halted};

    // Cycles from IF to the next IF; halt never retires.
    function automatic int ilen(input logic [5:0] op);
        case (op)
            ADD, SUB, AND_, OR_, SLT, SLL, ADDI, ORI, SW: return 4;
            LW:   return 5;
            BEQ:  return 3;
            HALT: return 0;
            default: return 2;
        endcase
    endfunction

    // Expected control word for phase ph (0 = fetch cycle) of an instruction with opcode op.
    function automatic logic [15:0] model_out(input int p, input logic [5:0] op, input logic z,
                                              input bit h, input logic rst);
        logic pcw, irw, asa, asb, ext, mr, mw, rd, m2r, rw;
        logic [1:0] pcs;
        logic [2:0] aop;
        int n;
        {pcw, irw, asa, asb, ext, mr, mw, rd, m2r, rw, pcs, aop} = '0;
        n = ilen(op);
        if (rst) return 16'h0000;
        if (h) return 16'h0001;
        if (p == 0) irw = 1'b1;
        if (p >= 2) begin
            case (op)
                ADD:  rd = 1'b1;
                SUB:  begin rd = 1'b1; aop = 3'd1; end
                AND_: begin rd = 1'b1; aop = 3'd2; end
                OR_:  begin rd = 1'b1; aop = 3'd3; end
                SLT:  begin rd = 1'b1; aop = 3'd5; end
                SLL:  begin rd = 1'b1; asa = 1'b1; aop = 3'd4; end
                ADDI: begin asb = 1'b1; ext = 1'b1; end
                ORI:  begin asb = 1'b1; aop = 3'd3; end
                LW, SW: begin asb = 1'b1; ext = 1'b1; end
                BEQ:  begin ext = 1'b1; aop = 3'd1; end
                default: ;
            endcase
        end
        if (op == LW && p == 3) mr = 1'b1;
        if (n > 0 && p == n - 1) begin
            pcw = 1'b1;
            pcs = (op == J) ? 2'd2 : (op == BEQ && z) ? 2'd1 : 2'd0;
            if (ilen(op) == 4 && op != SW) rw = 1'b1;
            if (op == LW) begin mr = 1'b1; m2r = 1'b1; rw = 1'b1; end
            if (op == SW) mw = 1'b1;
        end
        return {pcw, pcs, irw, asa, asb, ext, aop, mr, mw, rd, m2r, rw, 1'b0};
    endfunction

    always @(posedge CLK) begin
        if (Reset || resync) begin
            ph  <= 0;
            hlt <= 1'b0;
            if (Reset) mcnt <= '0;
        end else if (model_out(ph, bus.Opcode, bus.Zero, hlt, Reset)[15]) begin
            ph   <= 0;
            mcnt <= mcnt + 1;
        end else if (!hlt) begin
            if (ph == 1 && bus.Opcode == HALT) hlt <= 1'b1;
            else ph <= ph + 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [15:0] e;
            e = model_out(ph, bus.Opcode, bus.Zero, hlt, Reset);
            total++;
            if (dut_v === e && bus.InstrCount === mcnt) passed++;
            else $display("FAIL cycle @%0t: ctl=%h count=%0d, expected ctl=%h count=%0d",
                          $time, dut_v, bus.InstrCount, e, mcnt);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Fetch cycle with junk on Opcode/Zero (must be ignored), then present op in ID.
    task automatic begin_instr(input logic [5:0] op, input logic z);
        bus.Opcode = ~op;
        bus.Zero   = ~z;
        step();
        bus.Opcode = op;
        bus.Zero   = z;
    endtask

    task automatic run(input logic [5:0] op, input logic z);
        begin_instr(op, z);
        repeat (ilen(op) - 1) step();
        @(negedge CLK);
        chk("back_in_IF", 32'(bus.IRWrite), 32'd1);
    endtask

    initial begin
        bus.Opcode = 6'b0;
        bus.Zero   = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        step();
        Reset = 1'b0;
        @(negedge CLK);
        chk("reset_irwrite", 32'(bus.IRWrite), 32'd1);
        chk("reset_count", bus.InstrCount, 32'd0);

        begin_instr(ADD, 1'b0);
        step();
        step();
        @(negedge CLK);
        chk("add_wb_ctl", 32'(dut_v), 32'h800A);
        step();
        @(negedge CLK);
        chk("add_count", bus.InstrCount, 32'd1);

        begin_instr(BEQ, 1'b1);
        step();
        @(negedge CLK);
        chk("beq_z1_pcsrc", 32'(bus.PCSrc), 32'd1);
        chk("beq_z1_pcwrite", 32'(bus.PCWrite), 32'd1);
        chk("beq_aluop", 32'(bus.ALUOp), 32'd1);
        step();
        begin_instr(BEQ, 1'b0);
        step();
        @(negedge CLK);
        chk("beq_z0_pcsrc", 32'(bus.PCSrc), 32'd0);
        chk("beq_z0_pcwrite", 32'(bus.PCWrite), 32'd1);
        step();

        begin_instr(LW, 1'b0);
        step();
        step();
        step();
        @(negedge CLK);
        chk("lw_memtoreg", 32'(bus.MemToReg), 32'd1);
        chk("lw_regwrite", 32'(bus.RegWrite), 32'd1);
        step();
        begin_instr(SW, 1'b0);
        step();
        step();
        @(negedge CLK);
        chk("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        chk("sw_regwrite", 32'(bus.RegWrite), 32'd0);
        step();
        @(negedge CLK);
        chk("count_after_sw", bus.InstrCount, 32'd5);

        Reset = 1'b1;
        step();
        Reset = 1'b0;
        begin_instr(J, 1'b0);
        @(negedge CLK);
        chk("j_pcsrc", 32'(bus.PCSrc), 32'd2);
        chk("j_pcwrite", 32'(bus.PCWrite), 32'd1);
        step();
        begin_instr(NOP, 1'b0);
        @(negedge CLK);
        chk("nop_pcsrc", 32'(bus.PCSrc), 32'd0);
        chk("nop_pcwrite", 32'(bus.PCWrite), 32'd1);
        step();
        begin_instr(HALT, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            bus.Zero = i[0];
            @(negedge CLK);
            chk("halt_halted", 32'(bus.Halted), 32'd1);
            chk("halt_pcwrite", 32'(bus.PCWrite), 32'd0);
            step();
        end
        @(negedge CLK);
        chk("halt_count", bus.InstrCount, 32'd2);

        step();
        chk_en = 1'b0;
        resync = 1'b1;
        force dut.state_q = 4'd12;
        #1;
        chk("illegal_outputs", 32'(dut_v), 32'd0);
        release dut.state_q;
        step();
        resync = 1'b0;
        chk_en = 1'b1;
        @(negedge CLK);
        chk("illegal_to_IF", 32'(bus.IRWrite), 32'd1);
        chk("illegal_count", bus.InstrCount, 32'd2);

        begin_instr(LW, 1'b0);
        step();
        step();
        Reset = 1'b1;
        @(negedge CLK);
        chk("mem_reset_memread", 32'(bus.MemRead), 32'd0);
        chk("mem_reset_pcwrite", 32'(bus.PCWrite), 32'd0);
        step();
        Reset = 1'b0;
        @(negedge CLK);
        chk("mem_reset_IF", 32'(bus.IRWrite), 32'd1);
        chk("mem_reset_count", bus.InstrCount, 32'd0);

        run(SUB, 1'b1);
        run(OR_, 1'b0);
        run(AND_, 1'b1);
        run(SLT, 1'b0);
        run(SLL, 1'b1);
        run(ADDI, 1'b0);
        run(ORI, 1'b1);
        run(BEQ, 1'b1);
        chk("final_count", bus.InstrCount, 32'd8);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Finite-state sequencer for the multicycle CPU datapath.
- Reads the opcode held in IR and the ALU Zero flag each cycle.
- Drives every datapath 2:1 selector control, the ALU operation and all register/memory write enables.
- Steps each instruction through IF/ID/EXE/MEM/WB, holds in HALT, and counts retired instructions.

Parameters:
COUNT_WIDTH, 32, width of the retired-instruction counter InstrCount

Ports:
CLK  input  1  clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high
Opcode  input  6  IR[31:26]; valid from ID onward
Zero  input  1  ALU zero flag; sampled in EXE_BR
PCWrite  output  1  PC load enable
PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target
IRWrite  output  1  IR load enable
ALUSrcA  output  1  0 register A, 1 shamt
ALUSrcB  output  1  0 register B, 1 extended immediate
ExtSel  output  1  0 zero-extend, 1 sign-extend
ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt
MemRead  output  1  data memory read
MemWrite  output  1  data memory write
RegDst  output  1  0 rt, 1 rd
MemToReg  output  1  0 ALUOut, 1 MDR
RegWrite  output  1  register file write
Halted  output  1  high in HALT
InstrCount  output  COUNT_WIDTH  number of PCWrite pulses since reset

Behaviour:
- State register: 4 bits. IF=0, ID=1, EXE_AL=2, EXE_BR=3, EXE_LS=4, MEM=5, WB_AL=6, WB_LD=7, HALT=8.
- Outputs are combinational from state, Opcode and Zero.
- Any output not listed for a state is 0.
- Reset=1 at a clock edge: state becomes IF and InstrCount becomes 0.
- While Reset=1, all outputs are forced to 0 regardless of state, so no writes occur.
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, halt 111111.
- Per-opcode static controls, valid from EXE through WB:
  - add, sub, and, or, slt: RegDst=1, ALUSrcB=0, ALUOp per table.
  - sll: ALUSrcA=1, RegDst=1, ALUOp=100.
  - addi: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - ori: ALUSrcB=1, ExtSel=0, ALUOp=011.
  - lw/sw: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - beq: ALUOp=001, ExtSel=1.
- Transitions and actions:
  - IF: IRWrite=1; go to ID.
  - ID, j: PCWrite=1, PCSrc=10; go to IF.
  - ID, halt: go to HALT; no PCWrite.
  - ID, add/sub/and/or/slt/sll/addi/ori: go to EXE_AL.
  - ID, beq: go to EXE_BR.
  - ID, lw/sw: go to EXE_LS.
  - ID, undefined opcode: treated as nop. PCWrite=1, PCSrc=00; go to IF.
  - EXE_AL: go to WB_AL.
  - WB_AL: RegWrite=1, PCWrite=1, PCSrc=00; go to IF.
  - EXE_BR: PCWrite=1; PCSrc=01 if Zero=1, else 00; go to IF.
  - EXE_LS: go to MEM.
  - MEM, sw: MemWrite=1, PCWrite=1, PCSrc=00; go to IF.
  - MEM, lw: MemRead=1; go to WB_LD.
  - WB_LD: MemRead=1, MemToReg=1, RegWrite=1, PCWrite=1, PCSrc=00; go to IF.
  - HALT: Halted=1; stays until Reset.
- Cycle counts (IF to next IF): j/nop 2, beq 3, sw 4, ALU ops 4, lw 5.
- Exactly one PCWrite pulse per retired instruction; halt retires none.
- InstrCount increments by 1 on every edge where PCWrite=1 and Reset=0, and wraps modulo 2^COUNT_WIDTH.
- Illegal state encodings 9..15 go to IF on the next edge with all outputs 0.
- Reset asserted mid-instruction overrides every transition: next state IF, and writes are suppressed in the same cycle.
- Opcode or Zero changes in IF are ignored.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 during reset; first cycle after: IRWrite=1, state IF; InstrCount=0.
- add (000000) → IF,ID,EXE_AL,WB_AL. In WB_AL: RegWrite=1, RegDst=1, ALUOp=000, PCWrite=1, PCSrc=00. InstrCount=1 after.
- beq with Zero=1, then beq with Zero=0 → 3 cycles each; EXE_BR PCSrc=01, then 00; PCWrite=1 both times. ALUOp=001.
- lw (110001) then sw (110000) → lw 5 cycles with WB_LD MemToReg=1, RegWrite=1; sw 4 cycles with MEM MemWrite=1, RegWrite=0. InstrCount +2.
- j, opcode 101010, then halt → j: ID PCWrite=1, PCSrc=10. 101010: ID PCWrite=1, PCSrc=00. halt: HALT with Halted=1, PCWrite=0 for 20 cycles; InstrCount stays 2.
- Reset pulsed while in MEM for lw → no MemRead in that cycle; next state IF; InstrCount=0. Force state=12 → IF on the next edge.
